// File: rtl/calc_entry_fsm.sv
// Operand-entry and sequencing controller for a 16-bit signed calculator.
// Builds decimal operands from key events and issues operations to the ALU.
module calc_entry_fsm #(
  parameter int unsigned MAX_MAG = 32767
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        read_input,
  input  logic [3:0]  keypad_input,
  input  logic [2:0]  operator_input,
  input  logic        equal_input,
  output logic        key_read,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [2:0]  alu_op,
  output logic        alu_start,
  input  logic        alu_done,
  input  logic [15:0] alu_result,
  input  logic        alu_ovf,
  output logic [15:0] display_value,
  output logic        error
);

  typedef enum logic [2:0] {StEnterA, StEnterB, StExec, StResult, StError} state_e;

  localparam logic signed [20:0] MaxMag = 21'(MAX_MAG);

  state_e             state_q, state_d;
  logic signed [15:0] acc_q, acc_d, res_q, res_d, a_q, a_d, b_q, b_d;
  logic [2:0]         op_q, op_d, next_op_q, next_op_d;
  logic               b_seen_q, b_seen_d, chain_q, chain_d, armed_q, armed_d;
  logic               key_read_q, alu_start_q, alu_start_d;
  logic [15:0]        disp_q, disp_d;

  logic               accept, done_ok, is_eq, is_neg, is_bin, dig_ok;
  logic signed [20:0] acc_ext, dig_ext, app;
  logic signed [15:0] acc_app;

  assign is_eq   = equal_input;
  assign is_neg  = !equal_input && (operator_input == 3'b001);
  assign is_bin  = !equal_input && (operator_input inside {3'b010, 3'b011, 3'b100});
  assign dig_ok  = !equal_input && (operator_input == 3'b000) && (keypad_input <= 4'd9);
  assign accept  = read_input && armed_q && (state_q != StExec);
  // A done pulse coinciding with the start pulse is too early to be genuine.
  assign done_ok = (state_q == StExec) && alu_done && !alu_start_q;

  assign acc_ext = {{5{acc_q[15]}}, acc_q};
  assign dig_ext = {17'd0, keypad_input};
  assign app     = acc_q[15] ? (acc_ext * 21'sd10 - dig_ext) : (acc_ext * 21'sd10 + dig_ext);
  assign acc_app = ((app > MaxMag) || (app < -MaxMag)) ? acc_q : app[15:0];

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q     <= StEnterA;
      acc_q       <= '0;
      res_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      next_op_q   <= '0;
      b_seen_q    <= 1'b0;
      chain_q     <= 1'b0;
      armed_q     <= 1'b1;
      key_read_q  <= 1'b0;
      alu_start_q <= 1'b0;
      disp_q      <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      res_q       <= res_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      next_op_q   <= next_op_d;
      b_seen_q    <= b_seen_d;
      chain_q     <= chain_d;
      armed_q     <= armed_d;
      key_read_q  <= accept;
      alu_start_q <= alu_start_d;
      disp_q      <= disp_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    res_d     = res_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    next_op_d = next_op_q;
    b_seen_d  = b_seen_q;
    chain_d   = chain_q;
    armed_d   = accept ? 1'b0 : (!read_input ? 1'b1 : armed_q);

    unique case (state_q)
      StEnterA: begin
        if (accept) begin
          if (dig_ok) begin
            acc_d = acc_app;
          end else if (is_neg) begin
            acc_d = -acc_q;
          end else if (is_bin) begin
            a_d      = acc_q;
            op_d     = operator_input;
            acc_d    = '0;
            b_seen_d = 1'b0;
            state_d  = StEnterB;
          end
        end
      end
      StEnterB: begin
        if (accept) begin
          if (dig_ok) begin
            acc_d    = acc_app;
            b_seen_d = 1'b1;
          end else if (is_neg) begin
            acc_d = -acc_q;
          end else if (is_bin && !b_seen_q) begin
            op_d = operator_input;
          end else if (is_bin) begin
            b_d       = acc_q;
            chain_d   = 1'b1;
            next_op_d = operator_input;
            state_d   = StExec;
          end else if (is_eq && b_seen_q) begin
            b_d     = acc_q;
            chain_d = 1'b0;
            state_d = StExec;
          end
        end
      end
      StExec: begin
        if (done_ok) begin
          if (alu_ovf) begin
            state_d = StError;
          end else if (chain_q) begin
            a_d      = alu_result;
            op_d     = next_op_q;
            acc_d    = '0;
            b_seen_d = 1'b0;
            state_d  = StEnterB;
          end else begin
            res_d   = alu_result;
            state_d = StResult;
          end
        end
      end
      StResult: begin
        if (accept) begin
          if (dig_ok) begin
            acc_d   = {12'd0, keypad_input};
            state_d = StEnterA;
          end else if (is_bin) begin
            a_d      = res_q;
            op_d     = operator_input;
            acc_d    = '0;
            b_seen_d = 1'b0;
            state_d  = StEnterB;
          end else if (is_neg) begin
            res_d = -res_q;
            if (res_q == 16'sh8000) state_d = StError;
          end
        end
      end
      StError: begin
        if (accept && is_eq) begin
          acc_d   = '0;
          res_d   = '0;
          op_d    = '0;
          state_d = StEnterA;
        end
      end
      default: state_d = StEnterA;
    endcase

    alu_start_d = (state_d == StExec) && (state_q != StExec);

    unique case (state_d)
      StEnterA, StEnterB: disp_d = acc_d;
      StResult:           disp_d = res_d;
      StError:            disp_d = '0;
      default:            disp_d = disp_q;
    endcase
  end

  always_comb begin
    key_read      = key_read_q;
    alu_start     = alu_start_q;
    alu_a         = a_q;
    alu_b         = b_q;
    alu_op        = op_q;
    display_value = disp_q;
    error         = (state_q == StError);
  end

endmodule

// File: tb/tb_calc_entry_fsm.sv
// Scoreboard bench for calc_entry_fsm: key and ALU-request expectations are queued
// by the stimulus and checked by a monitor when the DUT acknowledges or starts.
module tb_calc_entry_fsm;

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic        read_input = 1'b0;
  logic [3:0]  keypad_input = '0;
  logic [2:0]  operator_input = '0;
  logic        equal_input = 1'b0;
  logic        key_read;
  logic [15:0] alu_a, alu_b;
  logic [2:0]  alu_op;
  logic        alu_start;
  logic        alu_done = 1'b0;
  logic [15:0] alu_result = '0;
  logic        alu_ovf = 1'b0;
  logic [15:0] display_value;
  logic        error;

  calc_entry_fsm #(.MAX_MAG(32767)) dut (
    .clk(clk), .RST(RST), .read_input(read_input), .keypad_input(keypad_input),
    .operator_input(operator_input), .equal_input(equal_input), .key_read(key_read),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
    .alu_done(alu_done), .alu_result(alu_result), .alu_ovf(alu_ovf),
    .display_value(display_value), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {logic [15:0] disp; logic err;} key_exp_t;
  typedef struct {logic [15:0] a; logic [15:0] b; logic [2:0] op;} alu_exp_t;
  typedef struct {logic [15:0] res; logic ovf; int lat;} resp_t;

  key_exp_t exp_key[$];
  alu_exp_t exp_alu[$];
  resp_t    resp_q[$];
  int n_vec = 0, n_err = 0, n_ack = 0, n_start = 0;

  function automatic void check(string name, logic [15:0] act, logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Monitor
  always @(negedge clk) begin
    if (!RST) begin
      if (key_read) begin
        n_ack++;
        if (exp_key.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_key_read: got 1 expected 0");
        end else begin
          key_exp_t e;
          e = exp_key.pop_front();
          check("key_display", display_value, e.disp);
          check("key_error", {15'd0, error}, {15'd0, e.err});
        end
      end
      if (alu_start) begin
        n_start++;
        if (exp_alu.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_alu_start: got 1 expected 0");
        end else begin
          alu_exp_t e;
          e = exp_alu.pop_front();
          check("alu_a", alu_a, e.a);
          check("alu_b", alu_b, e.b);
          check("alu_op", {13'd0, alu_op}, {13'd0, e.op});
        end
      end
    end
  end

  // ALU responder
  initial begin
    forever begin
      @(negedge clk);
      if (alu_start && !RST && resp_q.size() > 0) begin
        resp_t r;
        r = resp_q.pop_front();
        repeat (r.lat) @(posedge clk);
        #1 alu_done = 1'b1; alu_result = r.res; alu_ovf = r.ovf;
        @(posedge clk);
        #1 alu_done = 1'b0; alu_result = '0; alu_ovf = 1'b0;
      end
    end
  end

  task automatic press(input logic eq, input logic [2:0] op, input logic [3:0] d,
                       input logic [15:0] disp, input logic err, input int hold);
    bit got = 0;
    exp_key.push_back('{disp: disp, err: err});
    @(posedge clk);
    #1 equal_input = eq; operator_input = op; keypad_input = d; read_input = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (key_read) got = 1;
    end
    if (!got) begin
      n_vec++; n_err++;
      $display("FAIL key_ack_timeout: got no key_read expected one");
      void'(exp_key.pop_back());
    end
    repeat (hold) @(posedge clk);
    @(posedge clk);
    #1 read_input = 1'b0; equal_input = 1'b0; operator_input = '0; keypad_input = '0;
  endtask

  task automatic dig(input logic [3:0] d, input logic [15:0] disp);
    press(1'b0, 3'b000, d, disp, 1'b0, 0);
  endtask
  task automatic opk(input logic [2:0] op, input logic [15:0] disp);
    press(1'b0, op, 4'd0, disp, 1'b0, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 RST = 1'b1;
    repeat (2) @(posedge clk);
    #1 RST = 1'b0;
  endtask

  task automatic settle();
    repeat (8) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_idle(string tag);
    @(negedge clk);
    check({tag, "_key_read"}, {15'd0, key_read}, 16'd0);
    check({tag, "_alu_start"}, {15'd0, alu_start}, 16'd0);
    check({tag, "_alu_a"}, alu_a, 16'd0);
    check({tag, "_alu_b"}, alu_b, 16'd0);
    check({tag, "_alu_op"}, {13'd0, alu_op}, 16'd0);
    check({tag, "_display"}, display_value, 16'd0);
    check({tag, "_error"}, {15'd0, error}, 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, a0;
    repeat (3) @(posedge clk);
    #1 RST = 1'b0;
    check_idle("reset");

    // 123 + 45 = 168
    dig(4'd1, 16'd1); dig(4'd2, 16'd12); dig(4'd3, 16'd123);
    opk(3'b010, 16'd0);
    dig(4'd4, 16'd4); dig(4'd5, 16'd45);
    s0 = n_start;
    exp_alu.push_back('{a: 16'd123, b: 16'd45, op: 3'b010});
    resp_q.push_back('{res: 16'd168, ovf: 1'b0, lat: 3});
    press(1'b1, 3'b000, 4'd0, 16'd45, 1'b0, 0);
    settle();
    check("add_display", display_value, 16'd168);
    check("add_start_count", 16'(n_start - s0), 16'd1);

    // Held key acknowledged once
    a0 = n_ack;
    press(1'b0, 3'b000, 4'd7, 16'd7, 1'b0, 20);
    check("held_ack_count", 16'(n_ack - a0), 16'd1);
    dig(4'd7, 16'd77);

    // Magnitude limit
    do_reset();
    dig(4'd3, 16'd3); dig(4'd2, 16'd32); dig(4'd7, 16'd327);
    dig(4'd6, 16'd3276); dig(4'd7, 16'd32767);
    dig(4'd9, 16'd32767);
    opk(3'b001, 16'h8001);
    dig(4'd1, 16'h8001);
    dig(4'd12, 16'h8001);

    // Chain: 6 * 7 - 2
    do_reset();
    dig(4'd6, 16'd6); opk(3'b100, 16'd0); dig(4'd7, 16'd7);
    exp_alu.push_back('{a: 16'd6, b: 16'd7, op: 3'b100});
    resp_q.push_back('{res: 16'd42, ovf: 1'b0, lat: 2});
    opk(3'b011, 16'd7);
    settle();
    check("chain_alu_a", alu_a, 16'd42);
    check("chain_display", display_value, 16'd0);
    dig(4'd2, 16'd2);
    exp_alu.push_back('{a: 16'd42, b: 16'd2, op: 3'b011});
    resp_q.push_back('{res: 16'd40, ovf: 1'b0, lat: 1});
    press(1'b1, 3'b000, 4'd0, 16'd2, 1'b0, 0);
    settle();
    check("chain_result", display_value, 16'd40);

    // Overflow -> ERROR
    do_reset();
    dig(4'd9, 16'd9); opk(3'b100, 16'd0); dig(4'd9, 16'd9);
    exp_alu.push_back('{a: 16'd9, b: 16'd9, op: 3'b100});
    resp_q.push_back('{res: 16'd81, ovf: 1'b1, lat: 2});
    press(1'b1, 3'b000, 4'd0, 16'd9, 1'b0, 0);
    settle();
    check("ovf_error", {15'd0, error}, 16'd1);
    check("ovf_display", display_value, 16'd0);
    press(1'b0, 3'b000, 4'd5, 16'd0, 1'b1, 0);
    press(1'b0, 3'b010, 4'd0, 16'd0, 1'b1, 0);
    press(1'b1, 3'b000, 4'd0, 16'd0, 1'b0, 0);
    @(negedge clk);
    check("clear_alu_op", {13'd0, alu_op}, 16'd0);
    dig(4'd4, 16'd4);

    // Reset mid-EXEC, stray done afterwards
    do_reset();
    dig(4'd1, 16'd1); opk(3'b010, 16'd0); dig(4'd2, 16'd2);
    exp_alu.push_back('{a: 16'd1, b: 16'd2, op: 3'b010});
    press(1'b1, 3'b000, 4'd0, 16'd2, 1'b0, 0);
    @(posedge clk);
    #1 RST = 1'b1;
    @(posedge clk);
    #1 RST = 1'b0; alu_done = 1'b1; alu_result = 16'd99;
    @(posedge clk);
    #1 alu_done = 1'b0; alu_result = '0;
    check_idle("rst_exec");
    dig(4'd3, 16'd3);

    repeat (3) @(posedge clk);
    check("key_queue_drained", 16'(exp_key.size()), 16'd0);
    check("alu_queue_drained", 16'(exp_alu.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/calc_entry_fsm.md
# calc_entry_fsm

Operand-entry and sequencing controller for the 16-bit signed calculator. It sits directly downstream of the keypad scanner and consumes decoded key events over the `read_input`/`key_read` handshake. It builds decimal operands, latches the pending operator, and issues operations to the ALU over a start/done handshake. It drives the value shown on the display and an error flag.

## Interface
- `MAX_MAG`, default 32767: largest operand magnitude accepted during digit entry.
- `clk` in 1: system clock; all state changes on the rising edge.
- `RST` in 1: synchronous, active-high reset.
- `read_input` in 1: key event available; the key fields below are stable while it is high.
- `keypad_input` in 4: digit 0–9.
- `operator_input` in 3: 001 neg, 010 add, 011 sub, 100 mul; 000 means none.
- `equal_input` in 1: equals key.
- `key_read` out 1: one-cycle acknowledge; the key has been consumed.
- `alu_a`, `alu_b` out 16: signed operands; held stable from `alu_start` until `alu_done`.
- `alu_op` out 3: operator code, same encoding as `operator_input`.
- `alu_start` out 1: one-cycle request pulse.
- `alu_done` in 1: one-cycle completion pulse.
- `alu_result` in 16: signed result, valid with `alu_done`.
- `alu_ovf` in 1: overflow flag, valid with `alu_done`.
- `display_value` out 16: signed value to show.
- `error` out 1: high while in state ERROR.

## Operation
- Key class priority: `equal_input`=1 gives EQ. Otherwise a nonzero `operator_input` gives OP (001 is NEG). Otherwise the key is DIGIT.
- Re-arm flag `armed`:
  - A key is accepted only when `read_input`=1, `armed`=1 and state ≠ EXEC.
  - Acceptance clears `armed`.
  - `armed` sets again only after a cycle with `read_input`=0. A held key is never consumed twice.
- DIGIT append:
  - acc ≥ 0: new = acc×10 + d. acc < 0: new = acc×10 − d.
  - Compute at 21 bits. If |new| > MAX_MAG, the digit is consumed but acc is unchanged.
  - A `keypad_input` value > 9 is consumed and ignored.
- NEG: acc = −acc. Since |acc| ≤ MAX_MAG, this never overflows.
- States:
  - ENTER_A:
    - DIGIT/NEG act on acc.
    - OP add/sub/mul: `alu_a`←acc, `alu_op`←op, acc←0, `b_seen`←0, go to ENTER_B.
    - EQ: ignored.
  - ENTER_B:
    - DIGIT sets `b_seen`.
    - OP with `b_seen`=0: replaces `alu_op`.
    - OP with `b_seen`=1: `alu_b`←acc, `chain`←1, `next_op`←op, go to EXEC.
    - EQ with `b_seen`=1: `alu_b`←acc, `chain`←0, go to EXEC.
    - EQ with `b_seen`=0: ignored.
  - EXEC:
    - `alu_start` pulses on the first cycle of the state only.
    - On `alu_done` with `alu_ovf`=1: go to ERROR.
    - On `alu_done` with `chain`=1: `alu_a`←result, `alu_op`←`next_op`, acc←0, `b_seen`←0, go to ENTER_B.
    - Otherwise: latch result, go to RESULT.
  - RESULT:
    - DIGIT: acc←d, go to ENTER_A.
    - OP add/sub/mul: `alu_a`←result, `alu_op`←op, acc←0, go to ENTER_B.
    - NEG: result←−result; if result was −32768, go to ERROR.
    - EQ: ignored.
  - ERROR: EQ clears acc, result, `alu_op` and `error`, then goes to ENTER_A. Every other key is consumed and ignored.
- `display_value`:
  - acc in ENTER_A/ENTER_B.
  - Previous value held in EXEC.
  - Latched result in RESULT.
  - 0 in ERROR.

## Timing
- Reset values:
  - State ENTER_A, `armed`=1.
  - All data registers and all outputs 0: `key_read`, `alu_start`, `alu_a`, `alu_b`, `alu_op`, `display_value`, `error`.
- Key acceptance is sampled at edge t. `key_read`=1 during cycle t+1 only. The register and display update is visible in cycle t+1.
- `alu_start` is high in the first EXEC cycle, which is t+1 after the triggering key.
- `alu_done` is accepted at any cycle ≥ 1 after `alu_start`. The state change is visible the next cycle. There is no timeout.
- If `read_input` rises during EXEC, the key is held off (`key_read`=0) and accepted on the first cycle after leaving EXEC.
- RST wins over every event, including a concurrent `alu_done` or key acceptance. RST in mid-EXEC discards the operation, and a later stray `alu_done` is ignored outside EXEC.
- `alu_done` outside EXEC is ignored.

## Test plan
- Keys 1,2,3, add, 4,5, EQ; ALU returns 168 after 3 cycles.
  - `alu_start` pulses once with a=123, b=45, op=010.
  - `display_value`=168; state RESULT.
- Hold digit 7 (`read_input` high for 20 cycles).
  - Exactly one `key_read` pulse; acc=7.
  - Release, then press 7 again: acc=77.
- Digits 3,2,7,6,7, then 9.
  - acc=32767; the final digit is acknowledged but acc stays 32767.
  - NEG then 1: acc=−32767, digit still rejected.
- Chain 6, mul, 7, sub; ALU returns 42; then 2, EQ; ALU returns 40.
  - The second request has a=42, b=2, op=011.
  - `display_value`=40.
- 9, mul, 9, EQ with `alu_ovf`=1.
  - `error`=1 and `display_value`=0. Digits are acknowledged but ignored.
  - EQ returns to ENTER_A with all values 0.
- Assert RST two cycles after `alu_start`, then pulse `alu_done`.
  - Outputs are at reset values and the state stays ENTER_A.
  - The late `alu_done` has no effect.
